// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx_rtl transmitter between
// NUM_REQ byte-stream requesters. A grant is locked for a whole message and
// is released on a beat tagged last, or after MAX_BURST bytes.
// Optional feature macro: UART_ARB_PRIORITY_EN (requester 0 has absolute
// priority at arbitration time and does not advance the round-robin pointer).
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 16,
  localparam int unsigned ID_W     = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           uart_tx_data,
  output logic                 uart_tx_valid,
  input  logic                 uart_tx_ready,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [7:0]      beat_cnt;

  logic            win_found;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] idx;
  logic [7:0]      data_arr [NUM_REQ];
  logic            sel_valid;
  logic            sel_last;
  logic [7:0]      sel_data;
  logic            xfer;
  logic            rel_now;
  logic            keep_ptr;
  logic [ID_W-1:0] next_ptr;

  // Split the flat request bus into per-requester bytes.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[8*i +: 8];
    end
  end

  // Winner selection: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((32'(rr_ptr) + i) % NUM_REQ);
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
`ifdef UART_ARB_PRIORITY_EN
    if (req_valid[0]) begin
      win_found = 1'b1;
      win_id    = '0;
    end
`endif
  end

  // Pass-through from the granted requester; data forced to zero when not valid.
  always_comb begin
    sel_valid     = req_valid[grant_id];
    sel_last      = req_last[grant_id];
    sel_data      = data_arr[grant_id];
    uart_tx_valid = (state == GRANT) && sel_valid;
    uart_tx_data  = uart_tx_valid ? sel_data : 8'h00;
    req_ready     = '0;
    if (state == GRANT) begin
      req_ready[grant_id] = uart_tx_ready;
    end
    xfer     = uart_tx_valid && uart_tx_ready;
    rel_now  = sel_last || (beat_cnt == 8'(MAX_BURST - 1));
    next_ptr = (32'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_W'(1);
`ifdef UART_ARB_PRIORITY_EN
    keep_ptr = (grant_id == '0);
`else
    keep_ptr = 1'b0;
`endif
  end

  // Grant FSM: arbitrate in IDLE, count beats and release in GRANT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_id <= '0;
      busy     <= 1'b0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state    <= GRANT;
            grant_id <= win_id;
            busy     <= 1'b1;
            beat_cnt <= '0;
          end
        end
        GRANT: begin
          if (xfer) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (rel_now) begin
              state <= IDLE;
              busy  <= 1'b0;
              if (!keep_ptr) begin
                rr_ptr <= next_ptr;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed reset/stall cases plus
// randomized message traffic checked against a message-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned MB = 4;
  localparam int unsigned IW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     uart_tx_data;
  logic           uart_tx_valid;
  logic           uart_tx_ready;
  logic [IW-1:0]  grant_id;
  logic           busy;

  int errs   = 0;
  int checks = 0;

  // Pending bytes per requester, {last, data}.
  logic [8:0] srcq [N][$];
  // Expected downstream transfer sequence.
  int exp_id[$];
  int exp_data[$];
  int exp_rel[$];

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Message-level model: round-robin over non-empty queues, each grant takes
  // bytes until a last flag or MB bytes.
  task automatic build_model();
    logic [8:0] m [N][$];
    logic [8:0] e;
    int ptr, w, cnt, c;
    bit rel;
    exp_id.delete();
    exp_data.delete();
    exp_rel.delete();
    for (int i = 0; i < N; i++) m[i] = srcq[i];
    ptr = 0;
    while (1) begin
      w = -1;
`ifdef UART_ARB_PRIORITY_EN
      if (m[0].size() > 0) w = 0;
`endif
      for (int k = 0; k < N; k++) begin
        c = (ptr + k) % N;
        if (w < 0 && m[c].size() > 0) w = c;
      end
      if (w < 0) break;
      cnt = 0;
      rel = 1'b0;
      while (!rel) begin
        e = m[w].pop_front();
        cnt++;
        rel = e[8] || (cnt == MB);
        exp_id.push_back(w);
        exp_data.push_back(int'(e[7:0]));
        exp_rel.push_back(int'(rel));
      end
`ifdef UART_ARB_PRIORITY_EN
      if (w != 0) ptr = (w + 1) % N;
`else
      ptr = (w + 1) % N;
`endif
    end
  endtask

  // Random messages of 1..10 bytes, last flag on the final byte.
  task automatic gen_traffic();
    int nmsg, len;
    for (int i = 0; i < N; i++) begin
      srcq[i].delete();
      nmsg = int'($urandom_range(0, 3));
      for (int mi = 0; mi < nmsg; mi++) begin
        len = int'($urandom_range(1, 10));
        for (int b = 0; b < len; b++) begin
          srcq[i].push_back({(b == len - 1), 8'($urandom)});
        end
      end
    end
  endtask

  // Present queue heads; only the granted requester may bubble.
  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0 &&
          !(busy && (int'(grant_id) == i) && ($urandom_range(0, 3) == 0))) begin
        req_valid[i]      = 1'b1;
        req_data[8*i +: 8] = srcq[i][0][7:0];
        req_last[i]       = srcq[i][0][8];
      end else begin
        req_valid[i]      = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]       = 1'b0;
      end
    end
    uart_tx_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic run_round();
    int cyc;
    bit done, xfer, rel;
    logic [IW-1:0] g;
    logic [8:0] tmp;
    gen_traffic();
    build_model();
    rst_n = 1'b0;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    uart_tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_inputs();
    cyc = 0;
    done = (exp_id.size() == 0);
    while (!done && cyc < 4000) begin
      @(negedge clk);
      xfer = uart_tx_valid && uart_tx_ready;
      g = grant_id;
      rel = 1'b1;
      if (!busy) check("idle_quiet", {27'd0, req_ready, uart_tx_valid}, 32'd0);
      if (xfer) begin
        check("ready_onehot", 32'(req_ready), 32'(N'(1) << g));
        if (exp_id.size() == 0) begin
          check("extra_xfer", 32'd1, 32'd0);
        end else begin
          check("xfer_id", 32'(g), exp_id.pop_front());
          check("xfer_data", 32'(uart_tx_data), exp_data.pop_front());
          rel = exp_rel.pop_front();
        end
      end
      @(posedge clk);
      #1;
      if (xfer) begin
        tmp = srcq[g].pop_front();
        check("busy_after_xfer", 32'(busy), 32'(!rel));
      end
      drive_inputs();
      cyc++;
      done = (exp_id.size() == 0) && !busy;
    end
    check("round_in_budget", 32'(cyc < 4000), 32'd1);
    check("round_all_sent", exp_id.size(), 32'd0);
  endtask

  initial begin
    // Reset with every requester asking.
    rst_n = 1'b0;
    req_valid = '1;
    req_last = '0;
    req_data = 32'h44332211;
    uart_tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_tx_valid", 32'(uart_tx_valid), 32'd0);
    check("rst_tx_data", 32'(uart_tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("arb_latency_idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("first_grant_busy", 32'(busy), 32'd1);
    check("first_grant_id", 32'(grant_id), 32'd0);
    check("first_tx_valid", 32'(uart_tx_valid), 32'd1);
    check("stall_ready_low", 32'(req_ready), 32'd0);
    uart_tx_ready = 1'b1;
    #1;
    check("pass_ready", 32'(req_ready), 32'd1);
    check("pass_data", 32'(uart_tx_data), 32'h11);

    // Stall mid-message, then asynchronous reset.
    rst_n = 1'b0;
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_valid = 4'b0100;
    req_data = 32'h00A50000;
    @(posedge clk);
    #1;
    check("stall_grant_id", 32'(grant_id), 32'd2);
    check("stall_busy0", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_tx_valid", 32'(uart_tx_valid), 32'd0);
    check("stall_tx_data", 32'(uart_tx_data), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_valid = 4'b0101;
    @(posedge clk);
    #1;
    check("post_rst_grant", 32'(grant_id), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd1);

    // Randomized traffic against the model.
    for (int r = 0; r < 6; r++) run_round();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx_rtl transmitter between NUM_REQ byte-stream requesters using round-robin arbitration.
- Once a requester wins, the grant is locked for a whole message and released on a beat tagged last, or after MAX_BURST bytes.
- Sits between the system clients (debug console, status reporter, etc.) and the uart_tx_rtl tx_data/tx_valid/tx_ready interface.

Parameters:
- NUM_REQ, 4, number of requesters, 2..8.
- MAX_BURST, 16, maximum bytes per grant before a forced release, 1..255.
- ID_W, $clog2(NUM_REQ), width of grant_id (derived; do not override).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8*i+7:8*i].
- req_last  input  NUM_REQ  per-requester final-byte-of-message flag, qualified by req_valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit set.
- uart_tx_data  output  8  byte to uart_tx_rtl tx_data.
- uart_tx_valid  output  1  to uart_tx_rtl tx_valid.
- uart_tx_ready  input  1  from uart_tx_rtl tx_ready.
- grant_id  output  ID_W  index of the current/last granted requester.
- busy  output  1  high while a grant is locked.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, req_ready=0, uart_tx_valid=0, uart_tx_data=0, grant_id=0, busy=0, rr_ptr=0, beat_cnt=0.
- Transfer rules:
  - Downstream transfer occurs on a rising clk edge when uart_tx_valid and uart_tx_ready are both 1.
  - Upstream transfer for requester g occurs when req_valid[g] and req_ready[g] are both 1.
  - These two transfers are the same event.
- FSM state IDLE:
  - Scan req_valid starting at rr_ptr, wrapping modulo NUM_REQ; the first set bit wins.
  - On a winner: register grant_id=winner, set busy=1, clear beat_cnt, go to GRANT. This costs 1 cycle of arbitration latency.
  - With no requests: stay in IDLE; all outputs stay low.
- FSM state GRANT, combinational pass-through from requester g=grant_id:
  - uart_tx_valid = req_valid[g]; uart_tx_data = req_data[g].
  - req_ready[g] = uart_tx_ready; all other req_ready bits are 0.
  - uart_tx_data is 0 whenever uart_tx_valid is 0.
- Beat counting: on each transfer, beat_cnt increments (8-bit).
- Release: when the transfer carries req_last[g]=1, or beat_cnt reaches MAX_BURST-1 at transfer time:
  - go to IDLE, set rr_ptr=(g+1) mod NUM_REQ, set busy=0.
  - grant_id holds its value.
- Minimum gap: IDLE always lasts at least 1 cycle between grants, so no back-to-back re-arbitration in the same cycle.
- Stalled requester: if the granted requester drops req_valid mid-message, the grant stays locked (uart_tx_valid=0) until it resumes. There is no timeout.
- Non-granted requesters: their req_valid/req_data/req_last are ignored. They must hold data stable while unaccepted.
- Busy transmitter: uart_tx_ready=0 (uart mid-frame) stalls the transfer; uart_tx_valid stays asserted with stable data.
- Reset mid-operation:
  - Immediately returns to the reset values; any partially sent message is abandoned.
  - A byte already accepted by uart_tx_rtl is not aborted by this block.
- Single requester: the same requester may win again in the next IDLE if no other request is pending.

Optional Feature:
- Macro: UART_ARB_PRIORITY_EN.
- Defined:
  - In IDLE, requester 0 wins whenever req_valid[0]=1, regardless of rr_ptr.
  - Other requesters arbitrate round-robin as normal.
  - A locked grant is never preempted.
  - rr_ptr is not updated after a requester-0 grant.
- Undefined: pure round-robin as above.

Test Plan:
- Reset: hold rst_n=0 with all req_valid=1 -> req_ready=0, uart_tx_valid=0, busy=0, grant_id=0. Release reset -> grant to req0 exactly 1 cycle later.
- Single message: req1 sends 0x6D, 0xD5 (last on 0xD5), uart_tx_ready pulsing as a real uart_tx_rtl at 115200 baud / 50 MHz -> txd carries 0x6D then 0xD5, busy falls after the 2nd transfer, rr_ptr=2.
- Fairness: req0, req2 and req3 continuously request 1-byte messages -> grant order 0,2,3,0,2,3; no requester is granted twice while another is pending.
- Burst cap: MAX_BURST=4, req3 sends 10 bytes with no last while req1 is pending -> after the 4th byte req1 is granted; req3 resumes afterwards.
- Stall and reset: req2 drops req_valid after byte 1 of 3 -> busy stays 1 and uart_tx_valid=0. Assert rst_n=0 mid-stall -> busy=0 asynchronously, next grant starts from req0.
- UART_ARB_PRIORITY_EN defined: req0 asserts while req1's 3-byte message is locked -> req1 finishes first, then req0 wins over pending req2.
